// File: rtl/pck_len_commit_fifo.sv
// Packet-length/descriptor FIFO with speculative writes: words become readable only on
// commit, and a drop rewinds the write pointer to the last commit point.
module pck_len_commit_fifo #(
   parameter int DATA_WIDTH     = 12,
   parameter int DEPTH          = 32,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      hw_rst,
   input  logic                      sw_rst,
   input  logic                      wr_en,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      wr_commit,
   input  logic                      pck_drop,
   input  logic                      rd_en,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_valid,
   input  logic [ADDR_WIDTH:0]       almost_full_value,
   input  logic [ADDR_WIDTH:0]       almost_empty_value,
   output logic                      buffer_full,
   output logic                      buffer_empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [ADDR_WIDTH:0]       wr_lvl,
   output logic [ADDR_WIDTH:0]       spec_lvl,
   output logic                      overflow,
   output logic                      underflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   spec_ptr;
   logic [ADDR_WIDTH:0]   cmt_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  drop_eff;
   logic [PW:0]           af_thr;

   assign wr_lvl   = cmt_ptr - rd_ptr;
   assign spec_lvl = spec_ptr - rd_ptr;

   assign buffer_full  = (spec_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                         (spec_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
   assign buffer_empty = (wr_lvl == '0);

   // One extra bit so a margin larger than DEPTH goes negative and forces almost_full.
   assign af_thr       = (PW+1)'(DEPTH) - {1'b0, almost_full_value};
   assign almost_full  = af_thr[PW] | ({1'b0, spec_lvl} >= af_thr);
   assign almost_empty = ~hw_rst | (wr_lvl <= almost_empty_value);

   assign wr_acc   = wr_en & ~buffer_full & ~pck_drop;
   assign rd_acc   = rd_en & ~buffer_empty;
   assign drop_eff = pck_drop & (spec_ptr != cmt_ptr);

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[spec_ptr[ADDR_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge hw_rst) begin
      if (!hw_rst) begin
         spec_ptr  <= '0;
         cmt_ptr   <= '0;
         rd_ptr    <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         drop_cnt  <= '0;
      end else if (sw_rst) begin
         spec_ptr  <= '0;
         cmt_ptr   <= '0;
         rd_ptr    <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (pck_drop)
            spec_ptr <= cmt_ptr;
         else if (wr_acc)
            spec_ptr <= spec_ptr + 1'b1;

         if (wr_commit && !pck_drop)
            cmt_ptr <= wr_acc ? spec_ptr + 1'b1 : spec_ptr;

         if (rd_acc) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         end
         rd_valid <= rd_acc;

         overflow  <= wr_en & buffer_full & ~pck_drop;
         underflow <= rd_en & buffer_empty;

         if (drop_eff && !(&drop_cnt))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule
